serial_alu_cmd_rx: RTL and testbench

Synthesisable receiver for the serial ALU command protocol, generalised to operand width DATA_W and a buffered parallel output.
- Deserialises 11-bit packets from sin and assembles 2*NB data packets plus one control packet into a command.
- Checks packet count, stop bits, CRC4 and opcode.
- Pushes {A, B, op, err} into a DEPTH-entry FIFO, drained through a valid/ready handshake.
- Sits between the serial pin and the ALU datapath; replaces the fixed 32-bit, unbuffered front end.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_cmd_fifo.sv | 60 ++++++
 rtl/serial_alu_cmd_rx.sv | 169 ++++++++++++++++
 tb/tb_serial_alu_cmd_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types, constants and the CRC4 step for the serial ALU command receiver.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TYPE,
        ST_BITS,
        ST_STOP
    } pkt_state_e;

    localparam int unsigned ERR_FRAME = 3;
    localparam int unsigned ERR_DATA  = 2;
    localparam int unsigned ERR_CRC   = 1;
    localparam int unsigned ERR_OP    = 0;
    localparam int unsigned ERR_W     = 4;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned CRC_W     = 4;

    localparam logic PKT_DATA = 1'b0;
    localparam logic PKT_CTL  = 1'b1;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [ERR_W-1:0] err;
    } cmd_meta_t;

    // One MSB-first step of CRC4 with polynomial x^4+x+1.
    function automatic logic [CRC_W-1:0] crc4_step(input logic [CRC_W-1:0] state, input logic b);
        logic fb;
        fb = state[3] ^ b;
        return {state[2], state[1], state[0] ^ fb, fb};
    endfunction

    function automatic logic op_supported(input logic [OP_W-1:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous show-ahead FIFO; a pop in the same cycle frees the slot for a push to a full FIFO.
module alu_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/serial_alu_cmd_rx.sv
// Serial ALU command receiver: packet deserialiser, frame checker and buffered command output.
module serial_alu_cmd_rx
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [DATA_W-1:0] cmd_a,
    output logic [DATA_W-1:0] cmd_b,
    output logic [2:0]        cmd_op,
    output logic [3:0]        cmd_err,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned NB      = DATA_W / 8;
    localparam int unsigned ACC_W   = 2 * DATA_W;
    localparam int unsigned CNT_MAX = 2 * NB + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned META_W  = $bits(cmd_meta_t);
    localparam int unsigned FIFO_W  = ACC_W + META_W;

    pkt_state_e         state;
    pkt_state_e         state_nxt;
    logic [2:0]         bit_cnt;
    logic               pkt_type;
    logic [7:0]         shreg;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   data_cnt;
    logic [CRC_W-1:0]   crc_q;
    logic [CRC_W-1:0]   crc_nxt;
    logic               frame_err;
    logic               push_q;
    logic [FIFO_W-1:0]  push_data;
    logic               overflow_q;
    logic               busy_q;

    logic               err_data_c;
    logic [ERR_W-1:0]   err_c;
    logic [DATA_W-1:0]  a_c;
    logic [DATA_W-1:0]  b_c;
    cmd_meta_t          meta_c;

    logic [FIFO_W-1:0]  head;
    cmd_meta_t          head_meta;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    // Packet state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!sin) state_nxt = ST_TYPE;
            ST_TYPE: state_nxt = ST_BITS;
            ST_BITS: if (bit_cnt == 3'd7) state_nxt = ST_STOP;
            ST_STOP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // CRC runs over data bits, then the constant 1 in the ctl MSB slot, then the three op bits.
    always_comb begin
        crc_nxt = crc_q;
        if (pkt_type == PKT_DATA)  crc_nxt = crc4_step(crc_q, sin);
        else if (bit_cnt == 3'd0)  crc_nxt = crc4_step(crc_q, 1'b1);
        else if (bit_cnt <= 3'd3)  crc_nxt = crc4_step(crc_q, sin);
    end

    always_comb begin
        err_data_c        = (data_cnt != CNT_W'(2 * NB));
        err_c             = '0;
        err_c[ERR_FRAME]  = frame_err | ~sin;
        err_c[ERR_DATA]   = err_data_c;
        err_c[ERR_CRC]    = !err_data_c && (crc_q != shreg[3:0]);
        err_c[ERR_OP]     = !op_supported(shreg[6:4]);
        a_c               = err_data_c ? '0 : acc[DATA_W-1:0];
        b_c               = err_data_c ? '0 : acc[ACC_W-1:DATA_W];
        meta_c.op         = shreg[6:4];
        meta_c.err        = err_c;
    end

    // Packet datapath and frame accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            pkt_type  <= PKT_DATA;
            shreg     <= '0;
            acc       <= '0;
            data_cnt  <= '0;
            crc_q     <= '0;
            frame_err <= 1'b0;
            busy_q    <= 1'b0;
            push_q    <= 1'b0;
            push_data <= '0;
        end else begin
            push_q <= 1'b0;
            case (state)
                ST_IDLE: if (!sin) busy_q <= 1'b1;
                ST_TYPE: begin
                    pkt_type <= sin;
                    bit_cnt  <= '0;
                end
                ST_BITS: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    shreg   <= {shreg[6:0], sin};
                    crc_q   <= crc_nxt;
                end
                ST_STOP: begin
                    if (pkt_type == PKT_DATA) begin
                        acc <= {acc[ACC_W-9:0], shreg};
                        if (data_cnt != CNT_W'(CNT_MAX)) data_cnt <= data_cnt + CNT_W'(1);
                        if (!sin) frame_err <= 1'b1;
                    end else begin
                        push_q    <= 1'b1;
                        push_data <= {a_c, b_c, meta_c};
                        acc       <= '0;
                        data_cnt  <= '0;
                        crc_q     <= '0;
                        frame_err <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pop = cmd_ready && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow_q <= 1'b0;
        else        overflow_q <= push_q && fifo_full && !pop;
    end

    alu_cmd_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_q),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_meta = head[META_W-1:0];
    assign cmd_valid = !fifo_empty;
    assign cmd_a     = head[FIFO_W-1 -: DATA_W];
    assign cmd_b     = head[FIFO_W-1-DATA_W -: DATA_W];
    assign cmd_op    = head_meta.op;
    assign cmd_err   = head_meta.err;
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_alu_cmd_rx.sv
// Directed bench for serial_alu_cmd_rx: a 32-bit/depth-2 instance plus an 8-bit instance on the same line.
module tb_serial_alu_cmd_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sin;
    logic        ready;
    logic        ready8;

    logic        cmd_valid, overflow, busy;
    logic [31:0] cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_err;

    logic        v8, ovf8, busy8;
    logic [7:0]  a8, b8;
    logic [2:0]  op8;
    logic [3:0]  err8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_alu_cmd_rx #(.DATA_W(32), .DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .sin(sin),
        .cmd_valid(cmd_valid), .cmd_ready(ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_err(cmd_err),
        .overflow(overflow), .busy(busy)
    );

    serial_alu_cmd_rx #(.DATA_W(8), .DEPTH(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .sin(sin),
        .cmd_valid(v8), .cmd_ready(ready8),
        .cmd_a(a8), .cmd_b(b8), .cmd_op(op8), .cmd_err(err8),
        .overflow(ovf8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Polynomial long division of the message by x^4+x+1 (with four appended zeros).
    function automatic logic [3:0] div_step(input logic [3:0] r, input logic m);
        logic [4:0] t;
        t = {r, m};
        if (t[4]) t = t ^ 5'b10011;
        return t[3:0];
    endfunction

    function automatic logic [3:0] ref_crc(input logic [63:0] a, input logic [63:0] b,
                                           input int w, input logic [2:0] op);
        logic [3:0] r;
        r = 4'h0;
        for (int i = w - 1; i >= 0; i--) r = div_step(r, b[i]);
        for (int i = w - 1; i >= 0; i--) r = div_step(r, a[i]);
        r = div_step(r, 1'b1);
        for (int i = 2; i >= 0; i--) r = div_step(r, op[i]);
        for (int i = 0; i < 4; i++) r = div_step(r, 1'b0);
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        @(negedge clk);
    endtask

    task automatic send_pkt(input logic t, input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_bit(t);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
        sin = 1'b1;
    endtask

    // Returns at the negedge right after the ctl stop bit was sampled.
    task automatic send_frame(input logic [63:0] a, input logic [63:0] b, input int w,
                              input logic [2:0] op, input int ndata, input logic [3:0] crc_xor,
                              input int bad_stop, input logic chk_busy);
        logic [7:0] bytes [16];
        logic [3:0] crc;
        int         nb;
        nb = w / 8;
        for (int i = 0; i < nb; i++) begin
            bytes[i]      = b[(nb - 1 - i) * 8 +: 8];
            bytes[nb + i] = a[(nb - 1 - i) * 8 +: 8];
        end
        for (int i = 0; i < ndata; i++) begin
            send_pkt(1'b0, bytes[i], i != bad_stop);
            if (chk_busy) check("busy_mid_frame", 64'(busy), 64'd1);
        end
        crc = ref_crc(a, b, w, op) ^ crc_xor;
        send_pkt(1'b1, {1'b0, op, crc}, 1'b1);
    endtask

    // Empty FIFO, ready high: visible one edge after the stop sample, popped on the next.
    task automatic expect_cmd(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op, input logic [3:0] err);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_valid_early"}, 64'(cmd_valid), 64'd0);
        step();
        check({tag, "_valid"}, 64'(cmd_valid), 64'd1);
        check({tag, "_a"}, 64'(cmd_a), 64'(a));
        check({tag, "_b"}, 64'(cmd_b), 64'(b));
        check({tag, "_op"}, 64'(cmd_op), 64'(op));
        check({tag, "_err"}, 64'(cmd_err), 64'(err));
        step();
        check({tag, "_valid_after_pop"}, 64'(cmd_valid), 64'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        sin    = 1'b1;
        ready  = 1'b1;
        ready8 = 1'b1;
        step();
        step();
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_a", 64'(cmd_a), 64'd0);
        check("rst_err", 64'(cmd_err), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic ADD frame.
        send_frame(64'h1, 64'h2, 32, 3'b100, 8, 4'h0, -1, 1'b1);
        expect_cmd("t1", 32'h1, 32'h2, 3'b100, 4'b0000);

        // Short frame: seven data packets.
        send_frame(64'h0, 64'hFFFF_FFFF, 32, 3'b100, 7, 4'h0, -1, 1'b0);
        expect_cmd("t2", 32'h0, 32'h0, 3'b100, 4'b0100);

        // CRC error, then unsupported opcode.
        send_frame(64'hF0F0_F0F0, 64'h0F0F_0F0F, 32, 3'b000, 8, 4'h1, -1, 1'b0);
        expect_cmd("t3crc", 32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b000, 4'b0010);
        send_frame(64'h55, 64'hAA, 32, 3'b010, 8, 4'h0, -1, 1'b0);
        expect_cmd("t3op", 32'h55, 32'hAA, 3'b010, 4'b0001);

        // Bad stop bit in third data packet, then a clean frame.
        send_frame(64'h1234, 64'h5678, 32, 3'b001, 8, 4'h0, 2, 1'b1);
        expect_cmd("t4frm", 32'h1234, 32'h5678, 3'b001, 4'b1000);
        send_frame(64'h9, 64'h7, 32, 3'b001, 8, 4'h0, -1, 1'b0);
        expect_cmd("t4ok", 32'h9, 32'h7, 3'b001, 4'b0000);

        // Overflow on a full depth-2 FIFO.
        ready = 1'b0;
        send_frame(64'h1, 64'h0, 32, 3'b100, 8, 4'h0, -1, 1'b0);
        send_frame(64'h2, 64'h0, 32, 3'b100, 8, 4'h0, -1, 1'b0);
        send_frame(64'h3, 64'h0, 32, 3'b100, 8, 4'h0, -1, 1'b0);
        check("t5_ovf_before", 64'(overflow), 64'd0);
        step();
        check("t5_ovf_pulse", 64'(overflow), 64'd1);
        check("t5_head_a1", 64'(cmd_a), 64'h1);
        step();
        check("t5_ovf_clear", 64'(overflow), 64'd0);
        ready = 1'b1;
        check("t5_pop_a1", 64'(cmd_a), 64'h1);
        step();
        check("t5_valid_a2", 64'(cmd_valid), 64'd1);
        check("t5_pop_a2", 64'(cmd_a), 64'h2);
        step();
        check("t5_empty", 64'(cmd_valid), 64'd0);

        // Push to a full FIFO in the same cycle as a pop is accepted.
        ready = 1'b0;
        send_frame(64'h4, 64'h0, 32, 3'b100, 8, 4'h0, -1, 1'b0);
        send_frame(64'h5, 64'h0, 32, 3'b100, 8, 4'h0, -1, 1'b0);
        send_frame(64'h6, 64'h0, 32, 3'b100, 8, 4'h0, -1, 1'b0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("t5b_no_ovf", 64'(overflow), 64'd0);
        check("t5b_head_a5", 64'(cmd_a), 64'h5);
        step();
        check("t5b_no_ovf2", 64'(overflow), 64'd0);
        ready = 1'b1;
        step();
        check("t5b_head_a6", 64'(cmd_a), 64'h6);
        check("t5b_valid_a6", 64'(cmd_valid), 64'd1);
        step();
        check("t5b_empty", 64'(cmd_valid), 64'd0);

        // Reset in the middle of a frame with a command still buffered.
        ready = 1'b0;
        send_frame(64'h5, 64'h0, 32, 3'b100, 8, 4'h0, -1, 1'b0);
        for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'hC3, 1'b1);
        check("t6_busy_pre", 64'(busy), 64'd1);
        check("t6_valid_pre", 64'(cmd_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(cmd_valid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_a", 64'(cmd_a), 64'd0);
        check("t6_rst_op", 64'(cmd_op), 64'd0);
        step();
        rst_n = 1'b1;
        ready = 1'b1;
        send_frame(64'hDEAD_BEEF, 64'h1234_5678, 32, 3'b101, 8, 4'h0, -1, 1'b1);
        expect_cmd("t6sub", 32'hDEAD_BEEF, 32'h1234_5678, 3'b101, 4'b0000);

        // 8-bit instance after a clean reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        send_frame(64'h80, 64'h01, 8, 3'b100, 2, 4'h0, -1, 1'b0);
        check("w8_valid_early", 64'(v8), 64'd0);
        check("w8_busy_end", 64'(busy8), 64'd0);
        step();
        check("w8_valid", 64'(v8), 64'd1);
        check("w8_a", 64'(a8), 64'h80);
        check("w8_b", 64'(b8), 64'h01);
        check("w8_op", 64'(op8), 64'h4);
        check("w8_err", 64'(err8), 64'h0);
        step();
        check("w8_popped", 64'(v8), 64'd0);
        check("w8_no_ovf", 64'(ovf8), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
